pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch controller that owns the program counter and sequences instruction fetch from a multi-cycle instruction memory.
- Selects the next PC from sequential, branch, jump and exception sources, with fixed priority.
- Handles stall, redirects that arrive while a fetch is in flight, misaligned targets and fetch timeout.
- Sits between the control unit / branch logic and instruction memory; its `pc` output feeds the datapath.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on any exception.
- TIMEOUT, 16, max cycles to wait for imem_ack before a fetch-timeout exception; range 2..255.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold the current instruction; do not advance PC.
- branch_taken  input  1  take branch_target; sampled only when a redirect is legal (see Behaviour).
- branch_target  input  32  branch destination.
- jump  input  1  take jump_target.
- jump_target  input  32  jump destination.
- imem_req  output  1  fetch request; held high until acknowledged.
- imem_addr  output  32  fetch address; equals pc while imem_req is high.
- imem_ack  input  1  memory has returned the instruction this cycle.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32 (combinational).
- inst_valid  output  1  the instruction at pc is valid for the datapath.
- exc_valid  output  1  one-cycle pulse when an exception is taken.
- exc_cause  output  2  cause code: 01 = misaligned target, 10 = fetch timeout; 00 otherwise.
- epc  output  32  PC that caused the most recent exception.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pc = RESET_VECTOR; state = BOOT.
  - imem_req = 0, inst_valid = 0, exc_valid = 0, exc_cause = 0, epc = 0.
  - Pending-redirect register cleared; timeout counter cleared.
- State BOOT: one cycle, then FETCH.
- State FETCH:
  - imem_req = 1, imem_addr = pc; the timeout counter increments each cycle.
  - On imem_ack with no pending redirect: go to ISSUE. Minimum fetch latency is 1 cycle (req in cycle N, ack in N, inst_valid in N+1).
  - On imem_ack with a pending redirect: discard the fetched word (inst_valid stays 0), set pc = pending target, clear pending, and stay in FETCH with a fresh request the next cycle.
  - Counter reaches TIMEOUT without ack:
    - exc_valid pulse, exc_cause = 10, epc = pc.
    - pc = EXC_VECTOR; restart FETCH; counter cleared.
    - A late ack for the abandoned fetch is ignored only in the cycle the timeout fires.
- State ISSUE:
  - inst_valid = 1.
  - If stall = 1: pc, inst_valid and state are held; redirect inputs are ignored.
  - If stall = 0: the next PC is selected at the clock edge, in priority order:
    1. jump → jump_target
    2. branch_taken → branch_target
    3. otherwise pc_plus4
  - Then go to FETCH with inst_valid = 0.
- Redirects in FETCH/BOOT:
  - jump or branch_taken (same priority) is captured into the pending register; the latest one wins.
  - It takes effect at the next ack as described above.
- Misaligned target: a selected jump or branch target with [1:0] ≠ 0 is not loaded. Instead:
  - exc_valid pulse, exc_cause = 01, epc = pc of the redirecting instruction.
  - pc = EXC_VECTOR; go to FETCH.
  - This also applies to a pending target when it is applied.
- Exception priority:
  - Timeout is checked before ack in the same cycle (timeout wins).
  - Misalignment takes precedence over normal redirect loading.
- Wrap-around: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no exception.
- Reset mid-fetch: imem_req drops immediately (asynchronous); any in-flight ack is ignored until BOOT completes.
- exc_cause holds its value until the next exception; epc holds its value until the next exception.

Test Plan:
- Release reset with ack tied high, no redirects → pc sequence 0, 4, 8, 12, …; inst_valid high every other cycle; first imem_req one cycle after BOOT.
- At pc = 8 in ISSUE, assert jump = 1 with jump_target = 0x40 and branch_taken = 1 with branch_target = 0x20 → next pc = 0x40 (jump wins); no exception.
- Ack delayed 3 cycles; at pc = 4 assert branch_taken with target 0x100 during FETCH → fetched word at 4 discarded (inst_valid stays 0); next imem_addr = 0x100.
- Hold stall high for 5 cycles in ISSUE at pc = 0x10, with jump asserted → pc stays 0x10 and inst_valid stays 1 throughout; after stall drops with no redirect, pc = 0x14.
- Jump to 0x42 from pc = 0x30 → exc_valid pulse, exc_cause = 01, epc = 0x30, next imem_addr = 0x80.
- Never ack, TIMEOUT = 16 → exc_valid after 16 FETCH cycles, exc_cause = 10, epc = faulting pc, pc = 0x80; then assert reset_n = 0 mid-fetch → imem_req drops the same cycle and pc = 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch from
// a multi-cycle instruction memory.
//
// Ports:
//   clock          system clock, rising-edge active
//   reset_n        asynchronous active-low reset
//   stall          hold the issued instruction (pc frozen, redirects ignored)
//   branch_taken   take branch_target
//   branch_target  branch destination
//   jump           take jump_target (wins over branch_taken)
//   jump_target    jump destination
//   imem_req       fetch request, held until imem_ack
//   imem_addr      fetch address (mirrors pc)
//   imem_ack       memory returns the requested word this cycle
//   pc             address of the current instruction
//   pc_plus4       pc + 4, wraps modulo 2^32
//   inst_valid     instruction at pc is valid for the datapath
//   exc_valid      one-cycle pulse when an exception is taken
//   exc_cause      01 misaligned target, 10 fetch timeout (held)
//   epc            pc that caused the most recent exception (held)
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  // Counter value seen during the last permitted FETCH cycle.
  localparam logic [7:0] TIMEOUT_LAST   = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
  logic        exc_valid_reg, exc_valid_next;
  logic [1:0]  exc_cause_reg, exc_cause_next;
  logic [31:0] epc_reg, epc_next;

  logic        redir_any;
  logic [31:0] redir_target;
  logic        eff_valid;
  logic [31:0] eff_target;
  logic        exc_fire;
  logic [1:0]  exc_code;

  assign redir_any    = jump | branch_taken;
  assign redir_target = jump ? jump_target : branch_target;
  // A redirect arriving in the same cycle as the ack counts as pending, so
  // the newest redirect is never lost behind a word that is already stale.
  assign eff_valid    = redir_any | pend_valid_reg;
  assign eff_target   = redir_any ? redir_target : pend_target_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_BOOT;
      pc_reg          <= RESET_VECTOR;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 32'd0;
      tmo_cnt_reg     <= 8'd0;
      exc_valid_reg   <= 1'b0;
      exc_cause_reg   <= 2'b00;
      epc_reg         <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      exc_valid_reg   <= exc_valid_next;
      exc_cause_reg   <= exc_cause_next;
      epc_reg         <= epc_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    exc_valid_next   = 1'b0;
    exc_cause_next   = exc_cause_reg;
    epc_next         = epc_reg;
    exc_fire         = 1'b0;
    exc_code         = 2'b00;

    case (state_reg)
      ST_BOOT: begin
        state_next   = ST_FETCH;
        tmo_cnt_next = 8'd0;
        if (redir_any) begin
          pend_valid_next  = 1'b1;
          pend_target_next = redir_target;
        end
      end

      ST_FETCH: begin
        tmo_cnt_next = tmo_cnt_reg + 8'd1;
        if (redir_any) begin
          pend_valid_next  = 1'b1;
          pend_target_next = redir_target;
        end
        // Timeout is evaluated first: a late ack in this cycle is dropped.
        if (tmo_cnt_reg == TIMEOUT_LAST) begin
          exc_fire = 1'b1;
          exc_code = CAUSE_TIMEOUT;
        end else if (imem_ack) begin
          tmo_cnt_next    = 8'd0;
          pend_valid_next = 1'b0;
          if (eff_valid) begin
            // Fetched word belongs to the old path: discard and refetch.
            if (eff_target[1:0] != 2'b00) begin
              exc_fire = 1'b1;
              exc_code = CAUSE_MISALIGN;
            end else begin
              pc_next = eff_target;
            end
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (!stall) begin
          state_next   = ST_FETCH;
          tmo_cnt_next = 8'd0;
          if (redir_any) begin
            if (redir_target[1:0] != 2'b00) begin
              exc_fire = 1'b1;
              exc_code = CAUSE_MISALIGN;
            end else begin
              pc_next = redir_target;
            end
          end else begin
            pc_next = pc_plus4;
          end
        end
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase

    // Every exception vectors the same way and abandons any queued redirect.
    if (exc_fire) begin
      exc_valid_next  = 1'b1;
      exc_cause_next  = exc_code;
      epc_next        = pc_reg;
      pc_next         = EXC_VECTOR;
      state_next      = ST_FETCH;
      tmo_cnt_next    = 8'd0;
      pend_valid_next = 1'b0;
    end
  end

  assign pc         = pc_reg;
  assign pc_plus4   = pc_reg + 32'd4;
  assign imem_req   = (state_reg == ST_FETCH);
  assign imem_addr  = pc_reg;
  assign inst_valid = (state_reg == ST_ISSUE);
  assign exc_valid  = exc_valid_reg;
  assign exc_cause  = exc_cause_reg;
  assign epc        = epc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table, hand-written
// timeout / reset / wrap-around sequences, and a randomized run compared
// against a rule-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;
  localparam int          TIMEOUT      = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .RESET_VECTOR(RESET_VECTOR),
    .EXC_VECTOR(EXC_VECTOR),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .inst_valid(inst_valid),
    .exc_valid(exc_valid),
    .exc_cause(exc_cause),
    .epc(epc)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_inputs(input logic s, input logic j, input logic [31:0] jt,
                            input logic b, input logic [31:0] bt, input logic a);
    stall = s; jump = j; jump_target = jt;
    branch_taken = b; branch_target = bt; imem_ack = a;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        s;
    logic        j;
    logic [31:0] jt;
    logic        b;
    logic [31:0] bt;
    logic        a;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_iv;
    logic        e_exc;
    logic [1:0]  e_cause;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic s, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt, input logic a,
                              input logic [31:0] e_pc, input logic e_req, input logic e_iv,
                              input logic e_exc, input logic [1:0] e_cause,
                              input logic [31:0] e_epc);
    vec_t v;
    v.s = s; v.j = j; v.jt = jt; v.b = b; v.bt = bt; v.a = a;
    v.e_pc = e_pc; v.e_req = e_req; v.e_iv = e_iv; v.e_exc = e_exc;
    v.e_cause = e_cause; v.e_epc = e_epc;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Tracks what the sequencer should be doing in terms of the rules: whether
  // it is booting, holding an issued instruction or waiting on memory, how
  // long it has waited, and any redirect still owed.
  logic [31:0] m_pc;
  bit          m_boot, m_issuing, m_pend, m_exc;
  logic [31:0] m_pend_tgt, m_epc;
  logic [1:0]  m_cause;
  int          m_wait;

  task automatic model_reset();
    m_pc = RESET_VECTOR; m_boot = 1; m_issuing = 0; m_pend = 0; m_exc = 0;
    m_pend_tgt = 0; m_epc = 0; m_cause = 0; m_wait = 0;
  endtask

  task automatic model_exception(input logic [1:0] cause);
    m_exc = 1; m_cause = cause; m_epc = m_pc; m_pc = EXC_VECTOR;
    m_pend = 0; m_wait = 0; m_issuing = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    m_exc = 0;
    tgt = jump ? jump_target : branch_target;
    if (m_boot) begin
      m_boot = 0;
      if (jump || branch_taken) begin m_pend = 1; m_pend_tgt = tgt; end
    end else if (m_issuing) begin
      if (!stall) begin
        m_issuing = 0;
        m_wait = 0;
        if (jump || branch_taken) begin
          if (tgt % 4 != 0) model_exception(2'b01);
          else m_pc = tgt;
        end else begin
          m_pc = m_pc + 4;
        end
      end
    end else begin
      m_wait = m_wait + 1;
      if (jump || branch_taken) begin m_pend = 1; m_pend_tgt = tgt; end
      if (m_wait == TIMEOUT) begin
        model_exception(2'b10);
      end else if (imem_ack) begin
        m_wait = 0;
        if (m_pend) begin
          m_pend = 0;
          if (m_pend_tgt % 4 != 0) model_exception(2'b01);
          else m_pc = m_pend_tgt;
        end else begin
          m_issuing = 1;
        end
      end
    end
  endtask

  task automatic model_compare();
    chk("rnd_pc", pc, m_pc);
    chk("rnd_addr", imem_addr, m_pc);
    chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("rnd_req", {31'd0, imem_req}, {31'd0, !m_boot && !m_issuing});
    chk("rnd_inst_valid", {31'd0, inst_valid}, {31'd0, m_issuing});
    chk("rnd_exc_valid", {31'd0, exc_valid}, {31'd0, m_exc});
    chk("rnd_exc_cause", {30'd0, exc_cause}, {30'd0, m_cause});
    chk("rnd_epc", epc, m_epc);
  endtask

  initial begin
    int ack_pct;
    logic [31:0] rt;

    // Test plan sequence: sequential fetch, jump-over-branch, misaligned
    // jump, redirect during a slow fetch, stall with jump, misaligned branch.
    vecs[0]  = mk(0,0,0,0,0,1,           32'h0,   1,0,0,2'd0,32'h0);
    vecs[1]  = mk(0,0,0,0,0,1,           32'h0,   0,1,0,2'd0,32'h0);
    vecs[2]  = mk(0,0,0,0,0,1,           32'h4,   1,0,0,2'd0,32'h0);
    vecs[3]  = mk(0,0,0,0,0,1,           32'h4,   0,1,0,2'd0,32'h0);
    vecs[4]  = mk(0,0,0,0,0,1,           32'h8,   1,0,0,2'd0,32'h0);
    vecs[5]  = mk(0,0,0,0,0,1,           32'h8,   0,1,0,2'd0,32'h0);
    vecs[6]  = mk(0,1,32'h40,1,32'h20,1, 32'h40,  1,0,0,2'd0,32'h0);
    vecs[7]  = mk(0,0,0,0,0,0,           32'h40,  1,0,0,2'd0,32'h0);
    vecs[8]  = mk(0,0,0,0,0,1,           32'h40,  0,1,0,2'd0,32'h0);
    vecs[9]  = mk(0,1,32'h42,0,0,0,      32'h80,  1,0,1,2'd1,32'h40);
    vecs[10] = mk(0,0,0,0,0,0,           32'h80,  1,0,0,2'd1,32'h40);
    vecs[11] = mk(0,0,0,1,32'h100,0,     32'h80,  1,0,0,2'd1,32'h40);
    vecs[12] = mk(0,0,0,0,0,0,           32'h80,  1,0,0,2'd1,32'h40);
    vecs[13] = mk(0,0,0,0,0,1,           32'h100, 1,0,0,2'd1,32'h40);
    vecs[14] = mk(0,0,0,0,0,1,           32'h100, 0,1,0,2'd1,32'h40);
    vecs[15] = mk(1,1,32'h200,0,0,1,     32'h100, 0,1,0,2'd1,32'h40);
    vecs[16] = mk(1,1,32'h200,0,0,1,     32'h100, 0,1,0,2'd1,32'h40);
    vecs[17] = mk(0,0,0,0,0,1,           32'h104, 1,0,0,2'd1,32'h40);
    vecs[18] = mk(0,0,0,0,0,1,           32'h104, 0,1,0,2'd1,32'h40);
    vecs[19] = mk(0,0,0,1,32'h31,1,      32'h80,  1,0,1,2'd1,32'h104);

    // Reset state, sampled while reset is still asserted.
    reset_n = 1'b0;
    #12;
    chk("reset_pc", pc, RESET_VECTOR);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("reset_exc_cause", {30'd0, exc_cause}, 32'd0);
    chk("reset_epc", epc, 32'd0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_inputs(vecs[i].s, vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bt, vecs[i].a);
      step();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_pc);
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d_iv", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_iv});
      chk($sformatf("vec%0d_exc", i), {31'd0, exc_valid}, {31'd0, vecs[i].e_exc});
      chk($sformatf("vec%0d_cause", i), {30'd0, exc_cause}, {30'd0, vecs[i].e_cause});
      chk($sformatf("vec%0d_epc", i), epc, vecs[i].e_epc);
      $display("vec %0d: pc=%h req=%b iv=%b exc=%b cause=%b epc=%h",
               i, pc, imem_req, inst_valid, exc_valid, exc_cause, epc);
    end

    // Fetch timeout: no ack for TIMEOUT cycles; a late ack in the firing
    // cycle must be ignored. Then an asynchronous reset mid-fetch.
    do_reset();
    set_inputs(0, 0, 0, 0, 0, 0);
    step();                                   // BOOT -> FETCH
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk($sformatf("tmo_wait%0d_exc", k), {31'd0, exc_valid}, 32'd0);
      chk($sformatf("tmo_wait%0d_req", k), {31'd0, imem_req}, 32'd1);
    end
    imem_ack = 1'b1;                          // late ack in the timeout cycle
    step();
    imem_ack = 1'b0;
    chk("tmo_exc_valid", {31'd0, exc_valid}, 32'd1);
    chk("tmo_exc_cause", {30'd0, exc_cause}, 32'd2);
    chk("tmo_epc", epc, RESET_VECTOR);
    chk("tmo_pc", pc, EXC_VECTOR);
    chk("tmo_inst_valid", {31'd0, inst_valid}, 32'd0);
    $display("timeout: exc=%b cause=%b epc=%h pc=%h", exc_valid, exc_cause, epc, pc);
    step();
    chk("tmo_pulse_end", {31'd0, exc_valid}, 32'd0);
    chk("tmo_cause_hold", {30'd0, exc_cause}, 32'd2);
    chk("tmo_refetch_req", {31'd0, imem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_req", {31'd0, imem_req}, 32'd0);
    chk("async_reset_pc", pc, RESET_VECTOR);
    $display("async reset: req=%b pc=%h", imem_req, pc);
    imem_ack = 1'b1;                          // in-flight ack ignored through BOOT
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
    chk("post_reset_fetch_pc", pc, RESET_VECTOR);
    chk("post_reset_iv", {31'd0, inst_valid}, 32'd0);
    chk("post_reset_req", {31'd0, imem_req}, 32'd1);

    // Wrap-around: redirect captured in BOOT to the last word.
    do_reset();
    set_inputs(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step();                                   // BOOT -> FETCH, pending set
    set_inputs(0, 0, 0, 0, 0, 1);
    step();                                   // word discarded, pc loaded
    chk("wrap_load_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_load_iv", {31'd0, inst_valid}, 32'd0);
    step();
    chk("wrap_issue_iv", {31'd0, inst_valid}, 32'd1);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    step();
    chk("wrap_next_pc", pc, 32'h0);
    chk("wrap_no_exc", {31'd0, exc_valid}, 32'd0);
    $display("wrap: pc=%h exc=%b", pc, exc_valid);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    ack_pct = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(3))
          0: ack_pct = 100;
          1: ack_pct = 50;
          2: ack_pct = 10;
          default: ack_pct = 0;
        endcase
      end
      stall = ($urandom_range(99) < 25);
      jump = ($urandom_range(99) < 8);
      branch_taken = ($urandom_range(99) < 8);
      rt = $urandom;
      if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
      jump_target = rt;
      rt = $urandom;
      if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
      branch_target = rt;
      imem_ack = ($urandom_range(99) < ack_pct);
      @(posedge clock);
      model_step();
      #1;
      model_compare();
      if (exc_valid || m_exc)
        $display("rnd %0d: exc pc=%h cause=%b epc=%h", c, pc, exc_cause, epc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
